// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, bit-period math, frame constants.
// Build option UART_TX_PARITY_EN adds an even-parity bit (and the PAR state).
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  localparam int FRAME_BITS = 11;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam int FRAME_BITS = 10;
`endif

  localparam int DATA_BITS = 8;

  // Clocks per bit period; fractional remainder is dropped.
  function automatic int calc_lim(input int freq, input int baud);
    return freq / baud;
  endfunction

  function automatic int frame_clks(input int lim);
    return FRAME_BITS * lim;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..LIM-1, pulses tick on LIM-1, clr restarts it.
module uart_baud_gen #(
  parameter int LIM = 1250
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(LIM);

  if (LIM < 2) begin : g_lim_chk
    $error("uart_baud_gen: LIM must be at least 2");
  end

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(LIM - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)            cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_word_tx.sv
// Sends the top BYTE_SIZE bytes of a 32-bit word as 8N1 frames, MSB first.
// Build option UART_TX_PARITY_EN inserts an even-parity bit before stop.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int FREQ      = 12000000,
  parameter int BAUD      = 9600,
  parameter int BYTE_SIZE = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        tx,
  output logic        busy
);

  localparam int LIM = calc_lim(FREQ, BAUD);

  if (BYTE_SIZE < 1 || BYTE_SIZE > 4) begin : g_bsz_chk
    $error("uart_word_tx: BYTE_SIZE must be 1..4");
  end

  state_t      state, nxt;
  logic [31:0] sh, sh_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [1:0]  byte_cnt, byte_n;
  logic        tick, baud_clr, tx_n;
`ifdef UART_TX_PARITY_EN
  logic        par, par_n;
`endif

  // Counter restarts on every state change and is held at zero while idle.
  assign baud_clr = (state == S_IDLE) || (nxt != state);

  uart_baud_gen #(.LIM(LIM)) u_baud (
    .clk  (clk),
    .nrst (nrst),
    .clr  (baud_clr),
    .tick (tick)
  );

  always_comb begin
    nxt    = state;
    sh_n   = sh;
    bit_n  = bit_cnt;
    byte_n = byte_cnt;
    case (state)
      S_IDLE:
        if (data_valid && data_ready) begin
          sh_n   = data_in;
          byte_n = '0;
          nxt    = S_START;
        end
      S_START:
        if (tick) begin
          bit_n = '0;
          nxt   = S_DATA;
        end
      S_DATA:
        if (tick) begin
          sh_n  = {sh[30:0], 1'b0};
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            nxt = S_PAR;
`else
            nxt = S_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
      S_PAR:
        if (tick) nxt = S_STOP;
`endif
      S_STOP:
        if (tick) begin
          if (byte_cnt == 2'(BYTE_SIZE - 1)) begin
            nxt = S_IDLE;
          end else begin
            byte_n = byte_cnt + 2'd1;
            nxt    = S_START;
          end
        end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
`ifdef UART_TX_PARITY_EN
    par_n = (nxt == S_START) ? ^sh_n[31:24] : par;
`endif
    tx_n = 1'b1;
    case (nxt)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = sh_n[31];
`ifdef UART_TX_PARITY_EN
      S_PAR:   tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      sh         <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      tx         <= 1'b1;
      data_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= nxt;
      sh         <= sh_n;
      bit_cnt    <= bit_n;
      byte_cnt   <= byte_n;
      tx         <= tx_n;
      data_ready <= (nxt == S_IDLE);
      busy       <= (nxt != S_IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) par <= 1'b0;
    else       par <= par_n;
  end
`endif

endmodule
